// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter for the npc core.
// One outstanding transaction, alternating priority, response watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MW = DATA_W / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic {
        M_IFU,
        M_LSU
    } master_t;

    state_t        state;
    master_t       owner;
    master_t       last_grant;
    logic [CW-1:0] cnt;

    logic              ifu_gnt;
    logic              lsu_gnt;
    logic              req_valid_q;
    logic              ifu_resp_q;
    logic              lsu_resp_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MW-1:0]     wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    // Grant decision in IDLE: lone requester wins, ties go to the master not served last.
    always_comb begin
        ifu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (state == S_IDLE && !rst) begin
            if (ifu_req_valid && (!lsu_req_valid || last_grant == M_LSU)) begin
                ifu_gnt = 1'b1;
            end else if (lsu_req_valid) begin
                lsu_gnt = 1'b1;
            end
        end
    end

    assign ifu_req_ready  = ifu_gnt;
    assign lsu_req_ready  = lsu_gnt;
    assign ifu_resp_valid = ifu_resp_q;
    assign lsu_resp_valid = lsu_resp_q;
    assign ifu_rdata      = rdata_q;
    assign lsu_rdata      = rdata_q;
    assign ifu_err        = err_q;
    assign lsu_err        = err_q;
    assign mem_req_valid  = req_valid_q;
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;

    // Transaction FSM: latch request, hand to memory, wait with watchdog, pulse response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            owner       <= M_IFU;
            last_grant  <= M_LSU;
            cnt         <= '0;
            req_valid_q <= 1'b0;
            ifu_resp_q  <= 1'b0;
            lsu_resp_q  <= 1'b0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ifu_gnt || lsu_gnt) begin
                        owner       <= lsu_gnt ? M_LSU : M_IFU;
                        last_grant  <= lsu_gnt ? M_LSU : M_IFU;
                        addr_q      <= lsu_gnt ? lsu_addr : ifu_addr;
                        wen_q       <= lsu_gnt & lsu_wen;
                        wdata_q     <= lsu_gnt ? lsu_wdata : '0;
                        wmask_q     <= lsu_gnt ? lsu_wmask : '0;
                        req_valid_q <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_q <= 1'b0;
                        cnt         <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (mem_resp_valid) begin
                        rdata_q    <= wen_q ? '0 : mem_rdata;
                        err_q      <= 1'b0;
                        ifu_resp_q <= (owner == M_IFU);
                        lsu_resp_q <= (owner == M_LSU);
                        state      <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        rdata_q    <= '0;
                        err_q      <= 1'b1;
                        ifu_resp_q <= (owner == M_IFU);
                        lsu_resp_q <= (owner == M_LSU);
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    ifu_resp_q <= 1'b0;
                    lsu_resp_q <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter (TIMEOUT=8).
// Inputs driven 1ns after posedge, outputs sampled at negedge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_err        (ifu_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_err        (lsu_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr = 32'h1111_0000;
        lsu_addr = 32'h2222_0000;
        lsu_wen = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", {ifu_req_ready, lsu_req_ready});
        end
        n_chk++;
        if ({mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_valids: got %b want 000",
                     {mem_req_valid, ifu_resp_valid, lsu_resp_valid});
        end
        n_chk++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'd0) begin
            n_fail++;
            $display("FAIL reset_mem_fields: got %h/%b/%h/%h want all 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask);
        end
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read(input logic [31:0] addr, input logic [31:0] data);
        ifu_req_valid = 1'b1;
        ifu_addr = addr;
        @(negedge clk);
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL ifu_rd_ready: got %b want 10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({mem_req_valid, mem_wen, mem_wmask} !== 6'b1_0_0000 || mem_addr !== addr) begin
            n_fail++;
            $display("FAIL ifu_rd_memreq: got v=%b wen=%b mask=%h addr=%h want 1/0/0/%h",
                     mem_req_valid, mem_wen, mem_wmask, mem_addr, addr);
        end
        n_chk++;
        if (ifu_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_rd_busy_ready: got %b want 0", ifu_req_ready);
        end
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        n_chk++;
        if ({mem_req_valid, ifu_resp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL ifu_rd_wait: got %b want 00", {mem_req_valid, ifu_resp_valid});
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        n_chk++;
        if ({ifu_resp_valid, lsu_resp_valid, ifu_err} !== 3'b100 || ifu_rdata !== data) begin
            n_fail++;
            $display("FAIL ifu_rd_resp: got v=%b lv=%b err=%b rdata=%h want 1/0/0/%h",
                     ifu_resp_valid, lsu_resp_valid, ifu_err, ifu_rdata, data);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if ({ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL ifu_rd_pulse: got %b want 00", {ifu_resp_valid, lsu_resp_valid});
        end
        tick();
    endtask

    task automatic test_lsu_write();
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0100;
        lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wmask = 4'hF;
        @(negedge clk);
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL lsu_wr_ready: got %b want 01", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr = '0;
        lsu_wen = 1'b0;
        lsu_wdata = '0;
        lsu_wmask = '0;
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_0100 || mem_wen !== 1'b1 ||
                mem_wdata !== 32'hDEAD_BEEF || mem_wmask !== 4'hF) begin
                n_fail++;
                $display("FAIL lsu_wr_hold[%0d]: got v=%b a=%h w=%b d=%h m=%h want 1/80000100/1/deadbeef/f",
                         i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
            end
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        @(negedge clk);
        n_chk++;
        if (lsu_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lsu_wr_early: got %b want 0", lsu_resp_valid);
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        n_chk++;
        if ({lsu_resp_valid, ifu_resp_valid, lsu_err} !== 3'b100 || lsu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL lsu_wr_resp: got v=%b iv=%b err=%b rdata=%h want 1/0/0/0",
                     lsu_resp_valid, ifu_resp_valid, lsu_err, lsu_rdata);
        end
        tick();
        tick();
    endtask

    task automatic test_alternation();
        logic exp_lsu;
        logic [31:0] exp_addr;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr = 32'h0000_1000;
        lsu_addr = 32'h0000_2000;
        lsu_wen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_lsu = (k % 2) == 1;
            exp_addr = exp_lsu ? 32'h0000_2000 : 32'h0000_1000;
            @(negedge clk);
            n_chk++;
            if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
                n_fail++;
                $display("FAIL alt_grant[%0d]: got %b want %b", k,
                         {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
            end
            tick();
            mem_req_ready = 1'b1;
            @(negedge clk);
            n_chk++;
            if (mem_addr !== exp_addr) begin
                n_fail++;
                $display("FAIL alt_addr[%0d]: got %h want %h", k, mem_addr, exp_addr);
            end
            tick();
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata = 32'hA0 + k;
            tick();
            mem_resp_valid = 1'b0;
            @(negedge clk);
            n_chk++;
            if ({ifu_resp_valid, lsu_resp_valid} !== {~exp_lsu, exp_lsu} ||
                ifu_rdata !== 32'hA0 + k) begin
                n_fail++;
                $display("FAIL alt_resp[%0d]: got %b rdata=%h want %b rdata=%h", k,
                         {ifu_resp_valid, lsu_resp_valid}, ifu_rdata,
                         {~exp_lsu, exp_lsu}, 32'hA0 + k);
            end
            tick();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0200;
        lsu_wen = 1'b0;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_chk++;
            if (lsu_resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_early[M+%0d]: got %b want 0", i, lsu_resp_valid);
            end
            tick();
        end
        mem_resp_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({lsu_resp_valid, lsu_err, ifu_resp_valid} !== 3'b110 || lsu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL tmo_resp: got v=%b err=%b iv=%b rdata=%h want 1/1/0/0",
                     lsu_resp_valid, lsu_err, ifu_resp_valid, lsu_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            n_chk++;
            if ({ifu_resp_valid, lsu_resp_valid, mem_req_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL tmo_stray[%0d]: got %b want 000", i,
                         {ifu_resp_valid, lsu_resp_valid, mem_req_valid});
            end
        end
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        test_ifu_read(32'h8000_0004, 32'h0000_0413);
    endtask

    task automatic test_resp_at_timeout();
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_0300;
        lsu_wen = 1'b0;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
        end
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp_valid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        n_chk++;
        if ({lsu_resp_valid, lsu_err} !== 2'b10 || lsu_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL tmo_race: got v=%b err=%b rdata=%h want 1/0/cafef00d",
                     lsu_resp_valid, lsu_err, lsu_rdata);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0040;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr = 32'h0000_3000;
        lsu_addr = 32'h0000_4000;
        tick();
        @(negedge clk);
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid} !== 5'b0 ||
            {mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got r=%b%b v=%b%b%b addr=%h want all 0",
                     ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid,
                     lsu_resp_valid, mem_addr);
        end
        tick();
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rstmid_tie: got %b want 1000",
                     {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid});
        end
        tick();
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        mem_resp_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0000_3000 ||
            {ifu_resp_valid, lsu_resp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_next: got v=%b addr=%h resp=%b want 1/00003000/00",
                     mem_req_valid, mem_addr, {ifu_resp_valid, lsu_resp_valid});
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0093;
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h0000_0093) begin
            n_fail++;
            $display("FAIL rstmid_resp: got v=%b rdata=%h want 1/00000093",
                     ifu_resp_valid, ifu_rdata);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_ifu_read(32'h8000_0000, 32'h0010_0073);
        test_lsu_write();
        test_alternation();
        test_timeout();
        test_resp_at_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter that shares the single physical memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the npc core. It sits between the core's fetch/LSU logic and the memory backend (the DPI pmem bridge). It allows one outstanding transaction at a time and alternates priority on contention. A response watchdog converts a hung memory access into an error response instead of a core deadlock.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wmask width = DATA_W/8)
- TIMEOUT, 255, maximum cycles spent in WAIT before an error response; must be ≥ 1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  one-cycle pulse: ifu_rdata/ifu_err valid
- ifu_rdata  out  DATA_W  read data
- ifu_err  out  1  timeout error on this response
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write mask
- lsu_resp_valid  out  1  one-cycle pulse: lsu_rdata/lsu_err valid
- lsu_rdata  out  DATA_W  read data (0 for writes)
- lsu_err  out  1  timeout error on this response
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_W/1/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response; also asserted as the write acknowledge
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: ready is asserted combinationally only to the granted master.
  - Grant rule: if exactly one master is valid, that master is granted. If both are valid, the master not granted last time wins.
  - last_grant resets to LSU, so the first tie after reset goes to the IFU.
  - On accept (valid & ready): latch addr/wen/wdata/wmask and the owner; update last_grant; go to REQ.
  - IFU requests latch wen=0, wmask=0, wdata=0.
- REQ: mem_req_valid=1 with the latched fields, held stable. On mem_req_ready, clear the watchdog counter and go to WAIT.
- WAIT: the counter increments each cycle.
  - On mem_resp_valid: latch mem_rdata (forced to 0 for writes), set err=0, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: set rdata=0, err=1, go to RESP.
  - If mem_resp_valid and the timeout occur in the same cycle, the response wins (err=0).
- RESP: the owner's resp_valid=1 for exactly one cycle with rdata/err. The other master's resp_valid stays 0. Go to IDLE.
- mem_resp_valid outside WAIT is ignored. A late response after a timeout is dropped.
- Both ready outputs are 0 outside IDLE. Masters must hold valid and fields stable until ready.
- Reset (any state, including mid-transaction): the transaction is dropped with no response.
  - state=IDLE, last_grant=LSU, counter=0.
  - All outputs 0: the ready outputs are 0 during reset, and the latched mem_* fields are 0.

## Timing
- Accept at cycle N → mem_req_valid from N+1.
- If mem_req_ready at N+1 and mem_resp_valid at N+2 → master resp_valid at N+3. Minimum round trip: 3 cycles from accept to response.
- Next accept is possible at N+4 at the earliest (IDLE follows RESP). Throughput is ≤ 1 transaction per 4 cycles.
- Timeout: with mem_req_ready at cycle M and no response, err is reported at resp_valid cycle M+TIMEOUT+1.
- No combinational path from mem_* inputs to master outputs. Only the ready outputs depend combinationally on req_valid.

## Test plan
- Single IFU read, addr 0x80000000; memory accepts immediately and returns 0x00100073 one cycle later → ifu_resp_valid pulse 3 cycles after accept, rdata 0x00100073, err=0; lsu_resp_valid never set.
- LSU write, addr 0x80000100, wdata 0xDEADBEEF, wmask 0xF; mem_req_ready held low 5 cycles → mem_* fields stable all 5 cycles; lsu_resp_valid follows the ack with rdata=0.
- Both valid every cycle from reset for 6 transactions → grant order IFU, LSU, IFU, LSU, IFU, LSU.
- TIMEOUT=8, memory never responds → lsu_err=1, lsu_rdata=0 at M+9. A later stray mem_resp_valid in IDLE produces no response; the next request completes normally.
- mem_resp_valid asserted exactly on the timeout cycle → err=0 with the returned data.
- rst pulsed during WAIT → next cycle state IDLE and all outputs 0, no response for the dropped transaction. After rst is released, a tied request goes to the IFU first.
